// File: rtl/seq_pkg.sv
// Shared definitions for the seq_engine instruction sequencer: opcodes, FSM states
// and field-slice helpers for the op|ra|rb|rc / op|ra|imm instruction layout.
package seq_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_SEND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  function automatic logic [31:0] f_mask(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Helpers take the word zero-extended to 32 bits so one definition serves every NREG.
  function automatic logic [1:0] f_op(input logic [31:0] inst, input int ra_w);
    return 2'((inst >> (3 * ra_w)) & 32'd3);
  endfunction

  function automatic logic [31:0] f_ra(input logic [31:0] inst, input int ra_w);
    return (inst >> (2 * ra_w)) & f_mask(ra_w);
  endfunction

  function automatic logic [31:0] f_rb(input logic [31:0] inst, input int ra_w);
    return (inst >> ra_w) & f_mask(ra_w);
  endfunction

  function automatic logic [31:0] f_rc(input logic [31:0] inst, input int ra_w);
    return inst & f_mask(ra_w);
  endfunction

  function automatic logic [31:0] f_imm(input logic [31:0] inst, input int ra_w);
    return inst & f_mask(2 * ra_w);
  endfunction

endpackage

// File: rtl/seq_engine_if.sv
// Instruction input stream and SEND result stream of seq_engine, grouped as one bundle.
interface seq_engine_if #(
  parameter int DATA_W = 8,
  parameter int INST_W = 8
);

  logic              in_vld;
  logic [INST_W-1:0] in_inst;
  logic              in_rdy;
  logic              out_vld;
  logic [DATA_W-1:0] out_data;
  logic              out_rdy;

  modport master (
    output in_vld, in_inst, out_rdy,
    input  in_rdy, out_vld, out_data
  );

  modport slave (
    input  in_vld, in_inst, out_rdy,
    output in_rdy, out_vld, out_data
  );

endinterface

// File: rtl/seq_fifo.sv
// Small synchronous FIFO buffering instruction words; full/empty are registered flags.
module seq_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_push;
  logic             w_pop;

  // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
  assign w_push = push && !r_full;
  assign w_pop  = pop && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;

endmodule

// File: rtl/seq_engine.sv
// Instruction sequencer: FIFO-buffered PUSH/ADD/MULT/SEND over an NREG register file.
// Define SEQ_SAT_EN to saturate overflowing ADD/MULT results to all-ones instead of wrapping.
module seq_engine
  import seq_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int NREG       = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int RA_W       = $clog2(NREG),
  localparam int IMM_W      = 2 * RA_W,
  localparam int INST_W     = 2 + 3 * RA_W
) (
  input  logic              clk,
  input  logic              rst,
  seq_engine_if.slave       bus,
  output logic              exec_vld,
  output logic [INST_W-1:0] exec_inst,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic              busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t              r_state;
  logic [INST_W-1:0]   r_inst;
  logic [DATA_W-1:0]   r_regs [NREG];
  logic                r_out_vld;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_exec_vld;
  logic                r_ovf;

  logic [INST_W-1:0]   w_head;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic                w_pop;

  logic [1:0]          w_op;
  logic [RA_W-1:0]     w_ra;
  logic [RA_W-1:0]     w_rb;
  logic [RA_W-1:0]     w_rc;
  logic [IMM_W-1:0]    w_imm;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W:0]     w_sum;
  logic [2*DATA_W-1:0] w_prod;
  logic                w_wr_en;
  logic [RA_W-1:0]     w_wr_idx;
  logic [DATA_W-1:0]   w_wr_data;
  logic                w_ovf_set;

  assign w_pop = (r_state == ST_IDLE) && !w_empty;

  seq_fifo #(
    .WIDTH (INST_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_vld),
    .pop   (w_pop),
    .wdata (bus.in_inst),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_op  = f_op(32'(r_inst), RA_W);
  assign w_ra  = RA_W'(f_ra(32'(r_inst), RA_W));
  assign w_rb  = RA_W'(f_rb(32'(r_inst), RA_W));
  assign w_rc  = RA_W'(f_rc(32'(r_inst), RA_W));
  assign w_imm = IMM_W'(f_imm(32'(r_inst), RA_W));

  // Operands are read from the pre-edge register file, so ra/rb/rc may alias freely.
  assign w_a    = r_regs[w_ra];
  assign w_b    = r_regs[w_rb];
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_prod = (2*DATA_W)'(w_a) * (2*DATA_W)'(w_b);

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = w_rc;
    w_wr_data = '0;
    w_ovf_set = 1'b0;
    if (r_state == ST_EXEC) begin
      case (w_op)
        OP_PUSH: begin
          w_wr_en   = 1'b1;
          w_wr_idx  = w_ra;
          w_wr_data = DATA_W'(w_imm);
        end
        OP_ADD: begin
          w_wr_en   = 1'b1;
          w_wr_data = w_sum[DATA_W-1:0];
          w_ovf_set = w_sum[DATA_W];
        end
        OP_MULT: begin
          w_wr_en   = 1'b1;
          w_wr_data = w_prod[DATA_W-1:0];
          w_ovf_set = |w_prod[2*DATA_W-1:DATA_W];
        end
        default: begin
          w_wr_en = 1'b0;
        end
      endcase
`ifdef SEQ_SAT_EN
      if (w_ovf_set) w_wr_data = '1;
`else
      w_wr_data = w_wr_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[w_wr_idx] <= w_wr_data;
    end
  end

  // Sequencer FSM; every engine output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_inst     <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_exec_vld <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_exec_vld <= 1'b0;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_inst     <= w_head;
            r_exec_vld <= 1'b1;
            r_state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_op == OP_SEND) begin
            r_out_data <= w_a;
            r_out_vld  <= 1'b1;
            r_state    <= ST_SEND;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (bus.out_rdy) begin
            r_out_vld <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_rdy   = !w_full;
  assign bus.out_vld  = r_out_vld;
  assign bus.out_data = r_out_data;
  assign exec_vld     = r_exec_vld;
  assign exec_inst    = r_inst;
  assign ovf          = r_ovf;
  assign busy         = (w_count != '0) || (r_state != ST_IDLE);

endmodule

// File: doc/seq_engine.md
# seq_engine

Parametrised instruction sequencer core: the next-generation replacement for the lab-1 four-register PUSH/ADD/MULT/SEND datapath. It accepts instruction words over a valid/ready port, buffers them in a small FIFO, executes them against an N-entry register file, and emits SEND results on a back-pressured output stream. The top level feeds it from the switch/button debounce logic; the output stream feeds the UART transmit path.

## Interface
- `DATA_W`, 8: register and result width.
- `NREG`, 4: register count; power of two, ≥2. `RA_W = $clog2(NREG)`.
- `FIFO_DEPTH`, 4: instruction buffer depth; power of two, ≥2.
- Derived: `IMM_W = 2*RA_W`, `INST_W = 2 + 3*RA_W` (defaults: 4 and 8).

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_vld`  in  1  instruction word valid.
- `in_inst`  in  INST_W  instruction word.
- `in_rdy`  out  1  FIFO not full.
- `out_vld`  out  1  SEND result valid.
- `out_data`  out  DATA_W  SEND result.
- `out_rdy`  in  1  downstream accepts.
- `exec_vld`  out  1  one-cycle pulse: instruction executing this cycle.
- `exec_inst`  out  INST_W  instruction executing.
- `ovf`  out  1  sticky arithmetic overflow.
- `ovf_clr`  in  1  clears `ovf`.
- `busy`  out  1  FIFO non-empty or state ≠ IDLE.

## Operation
- Encoding (MSB first): op[1:0], ra, then rb,rc or imm. 00 PUSH: `r[ra] <= zero-extended imm`. 01 ADD: `r[rc] <= r[ra]+r[rb]`. 10 MULT: `r[rc] <= r[ra]*r[rb]`. 11 SEND: emit `r[ra]`; low 2*RA_W bits ignored.
- Arithmetic: full-precision result (DATA_W+1 bits for ADD, 2*DATA_W for MULT); result truncated to low DATA_W bits; any nonzero discarded bit sets `ovf`. PUSH and SEND never set `ovf`.
- `ovf`: set on overflow, cleared by `ovf_clr`; when both occur in the same cycle, set wins.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into `inst_q` and go to EXEC.
  - EXEC: `exec_vld=1`, `exec_inst=inst_q`. PUSH/ADD/MULT write the register file at the clock edge, then go to IDLE. SEND loads `out_data`, sets `out_vld`, and goes to SEND.
  - SEND: hold `out_vld` and `out_data` stable until `out_rdy` is sampled high, then clear `out_vld` and go to IDLE.
- FIFO: push when `in_vld && in_rdy`. `in_rdy = !full`, registered from the current count. A push is refused when the FIFO is full, even if a pop happens in the same cycle. Push and pop in the same non-full cycle leave the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Register file: read-before-write within EXEC. `ra`, `rb` and `rc` may alias (for example ADD r2,r2,r2 doubles r2).
- Reset values: all registers 0, FIFO empty, state IDLE, `in_rdy=1`, `out_vld=0`, `out_data=0`, `exec_vld=0`, `exec_inst=0`, `ovf=0`, `busy=0`. A reset mid-SEND drops `out_vld` at that edge; the pending result is lost.

## Timing
- FIFO write to earliest EXEC: 2 cycles (push edge → IDLE pop edge → EXEC).
- Non-SEND throughput: 1 instruction per 2 cycles.
- SEND: `out_vld` rises on the edge leaving EXEC. The handshake completes on the first edge with `out_rdy=1`. The next EXEC comes ≥2 cycles after the handshake.
- `out_vld` never depends combinationally on `out_rdy`. All outputs are registered except `busy`.

## Configuration
- `SEQ_SAT_EN` defined: on overflow, ADD/MULT write all-ones (`{DATA_W{1'b1}}`) instead of the truncated value. `ovf` behaves identically.
- `SEQ_SAT_EN` undefined: wrap-around (truncate).

## Structure
- `seq_pkg`: opcode localparams (`OP_PUSH`, `OP_ADD`, `OP_MULT`, `OP_SEND`), FSM state encoding, field-slice helper functions for ra/rb/rc/imm given RA_W.
- Sub-module `seq_fifo` (parameters WIDTH, DEPTH; ports push/pop/full/empty/count). The FSM and register file live in `seq_engine`.

## Test plan
- Defaults, sequence PUSH r0,4; PUSH r0,0; PUSH r1,3; MULT r0,r1,r2; ADD r2,r0,r3; SEND r0..r3 with `out_rdy=1` → `out_data` 0x00, 0x03, 0x00, 0x00 in order; 9 `exec_vld` pulses; `ovf=0`.
- PUSH r0,15; PUSH r1,15; MULT r0,r1,r2 → r2=0xE1, `ovf=0`. Then ADD r2,r2,r3 → SEND r3 gives 0xC2 (0xFF with `SEQ_SAT_EN`) and `ovf=1`. Then pulse `ovf_clr` → `ovf=0`.
- MULT r2,r2,r0 with r2=0xE1 → 0xC1 wrapped (0xFF saturated); assert `ovf_clr` in the overflow cycle → `ovf` stays 1.
- SEND with `out_rdy=0` for 10 cycles while streaming 6 instructions → `out_vld` and `out_data` stable; `in_rdy` falls after 4 accepted words. Raise `out_rdy` → handshake, all words drain in order, `busy` falls.
- Assert `rst` during the SEND state and during a full FIFO → next cycle `out_vld=0`, `in_rdy=1`, `busy=0`, a SEND of every register returns 0.
- NREG=8, DATA_W=16 (INST_W=11): PUSH r7,63; ADD r7,r7,r6; SEND r6 → 0x007E.
